// File: rtl/booth_iter_mul_ctrl.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle, valid/ready on both sides.
// Optional early exit on redundant upper multiplier bits when BOOTH_EARLY_TERM_EN is defined.
module booth_iter_mul_ctrl #(
  parameter int unsigned M = 16,
  parameter int unsigned N = 16
) (
  input  logic           clk,
  input  logic           rstN,
  input  logic           inValid,
  output logic           inReady,
  input  logic           signedFlag,
  input  logic [M-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           outValid,
  input  logic           outReady,
  output logic [M+N-1:0] product,
  output logic           busy
);

  localparam int unsigned NPP  = N / 2 + 1;
  localparam int unsigned PW   = 2 * NPP + 1;
  localparam int unsigned PADW = PW - N - 1;
  localparam int unsigned AW   = M + N + 2;
  localparam int unsigned CW   = $clog2(NPP + 1);
  localparam bit          OddN = (N % 2) == 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [M-1:0]    a_q, a_d;
  logic            sign_q, sign_d;
  logic [PW-1:0]   mult_q, mult_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [2:0]      win;
  logic            dig_zero, dig_neg, dig_two;
  logic            last;
  logic            early;
  logic [AW-1:0]   a_ext, mag, pp, pp_sh;

  // Recoder: window bits [2i+2:2i] -> {zero, neg, two}
  always_comb begin
    win      = 3'(mult_q >> (2 * cnt_q));
    last     = (cnt_q == CW'(NPP - 1));
    dig_neg  = win[2];
    dig_two  = (win == 3'b011) || (win == 3'b100);
    // Top digit only sees zero padding; for signed even-N the lower digits already
    // account for the sign, so it must contribute nothing.
    dig_zero = (win == 3'b000) || (win == 3'b111) || (sign_q && !OddN && last);
  end

  always_comb begin
    a_ext = sign_q ? {{(AW - M){a_q[M-1]}}, a_q} : {{(AW - M){1'b0}}, a_q};
    mag   = dig_two ? (a_ext << 1) : a_ext;
    pp    = dig_zero ? '0 : (dig_neg ? (~mag + AW'(1)) : mag);
    pp_sh = pp << (2 * cnt_q);
  end

`ifdef BOOTH_EARLY_TERM_EN
  logic [PW-1:0] chk_vec;
  logic          rem_zero, rem_ones;

  // Pad bits are treated as sign extension in signed mode so all-ones tails terminate.
  always_comb begin
    chk_vec  = mult_q;
    rem_zero = 1'b1;
    rem_ones = 1'b1;
    for (int k = N + 1; k < PW; k++) begin
      chk_vec[k] = sign_q & mult_q[N];
    end
    for (int k = 0; k < PW; k++) begin
      if (k >= 2 * int'(cnt_q) + 2) begin
        rem_zero = rem_zero & ~chk_vec[k];
        rem_ones = rem_ones & chk_vec[k];
      end
    end
  end

  assign early = rem_zero | (sign_q & rem_ones);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    sign_d  = sign_q;
    mult_d  = mult_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (inValid) begin
          a_d     = multiplicand;
          sign_d  = signedFlag;
          mult_d  = {{PADW{signedFlag & multiplier[N-1] & OddN}}, multiplier, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_q + pp_sh;
        cnt_d = cnt_q + CW'(1);
        if (last || early) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (outReady) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= StIdle;
      a_q     <= '0;
      sign_q  <= 1'b0;
      mult_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      sign_q  <= sign_d;
      mult_q  <= mult_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Guard bits only absorb intermediate carries; the product never needs them.
  logic unused_acc_msb;
  assign unused_acc_msb = ^acc_q[AW-1:M+N];

  assign inReady  = (state_q == StIdle);
  assign outValid = (state_q == StDone);
  assign busy     = (state_q == StRun) || (state_q == StDone);
  assign product  = acc_q[M+N-1:0];

endmodule

// File: tb/tb_booth_iter_mul_ctrl.sv
// Self-checking bench for booth_iter_mul_ctrl: vector table, scoreboard queue, corner sequences.
module tb_booth_iter_mul_ctrl;

  logic        clk;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic        signedFlag;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        outValid;
  logic        outReady;
  logic [31:0] product;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  booth_iter_mul_ctrl #(.M(16), .N(16)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .inValid      (inValid),
    .inReady      (inReady),
    .signedFlag   (signedFlag),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .outValid     (outValid),
    .outReady     (outReady),
    .product      (product),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        ua;
    logic [31:0]        ub;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    ua = {16'h0, a};
    ub = {16'h0, b};
    if (s) return sa * sb;
    return ua * ub;
  endfunction

  function automatic int lat_model(input logic [15:0] b, input logic s);
`ifdef BOOTH_EARLY_TERM_EN
    logic [18:0] v;
    logic [18:0] all1;
    logic [18:0] rest;
    logic [18:0] ones;
    v    = {{2{s & b[15]}}, b, 1'b0};
    all1 = 19'h7FFFF;
    for (int i = 0; i < 9; i++) begin
      rest = v >> (2 * i + 2);
      ones = all1 >> (2 * i + 2);
      if (rest == 19'h0 || (s && rest == ones)) return i + 1;
    end
    return 9;
`else
    return (b === 16'hx && s) ? 0 : 9;
`endif
  endfunction

  // Starts one cycle after a posedge with the DUT idle; returns idle again.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [31:0] exp);
    int lat;
    int exp_lat;
    logic [31:0] want;
    exp_lat = lat_model(b, s);
    check({name, " inReady idle"}, inReady, 1'b1);
    multiplicand = a;
    multiplier   = b;
    signedFlag   = s;
    inValid      = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    inValid      = 1'b0;
    multiplicand = ~a;
    multiplier   = ~b;
    signedFlag   = ~s;
    lat = 0;
    while (outValid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, lat, exp_lat);
    if (outValid === 1'b1 && sb_q.size() > 0) begin
      want = sb_q.pop_front();
      check({name, " product"}, product, want);
      check({name, " busy in done"}, busy, 1'b1);
      check({name, " inReady in done"}, inReady, 1'b0);
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      check({name, " outValid after take"}, outValid, 1'b0);
      check({name, " inReady after take"}, inReady, 1'b1);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    logic [31:0] held;
    int          wait_cnt;

    vecs[0]  = '{a: 16'hFFFF, b: 16'hFFFF, s: 1'b0, p: 32'hFFFE0001};
    vecs[1]  = '{a: 16'hFFFD, b: 16'h0007, s: 1'b1, p: 32'hFFFFFFEB};
    vecs[2]  = '{a: 16'h8000, b: 16'h8000, s: 1'b1, p: 32'h40000000};
    vecs[3]  = '{a: 16'hFFFF, b: 16'hFFFF, s: 1'b1, p: 32'h00000001};
    vecs[4]  = '{a: 16'h0003, b: 16'h0005, s: 1'b0, p: 32'h0000000F};
    vecs[5]  = '{a: 16'h8000, b: 16'h8000, s: 1'b0, p: 32'h40000000};
    vecs[6]  = '{a: 16'h7FFF, b: 16'h8000, s: 1'b1, p: 32'hC0008000};
    vecs[7]  = '{a: 16'h1234, b: 16'h0000, s: 1'b0, p: 32'h00000000};
    vecs[8]  = '{a: 16'h0001, b: 16'hFFFF, s: 1'b1, p: 32'hFFFFFFFF};
    vecs[9]  = '{a: 16'hFFFF, b: 16'h0001, s: 1'b0, p: 32'h0000FFFF};
    vecs[10] = '{a: 16'h0002, b: 16'h0001, s: 1'b0, p: 32'h00000002};
    vecs[11] = '{a: 16'h0005, b: 16'hFFFF, s: 1'b1, p: 32'hFFFFFFFB};

    rstN         = 1'b0;
    inValid      = 1'b0;
    outReady     = 1'b0;
    signedFlag   = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset inReady", inReady, 1'b1);
    check("reset outValid", outValid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset product", product, 32'h0);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p);
    end

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", i), ra, rb, rs, model(ra, rb, rs));
    end

    // Backpressure: DONE held for 5 cycles while new operands are offered.
    multiplicand = 16'h00FF;
    multiplier   = 16'h0101;
    signedFlag   = 1'b0;
    inValid      = 1'b1;
    sb_q.push_back(32'h0000FFFF);
    @(posedge clk);
    #1;
    inValid  = 1'b0;
    wait_cnt = 0;
    while (outValid !== 1'b1 && wait_cnt < 40) begin
      @(posedge clk);
      #1;
      wait_cnt++;
    end
    check("bp reaches done", outValid, 1'b1);
    held = product;
    check("bp product", held, 32'h0000FFFF);
    multiplicand = 16'h0007;
    multiplier   = 16'h0007;
    inValid      = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp outValid held %0d", c), outValid, 1'b1);
      check($sformatf("bp inReady low %0d", c), inReady, 1'b0);
      check($sformatf("bp product held %0d", c), product, 32'h0000FFFF);
      @(posedge clk);
      #1;
    end
    inValid = 1'b0;
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    outReady = 1'b1;
    check("bp inReady same cycle", inReady, 1'b0);
    @(posedge clk);
    #1;
    outReady = 1'b0;
    check("bp inReady after take", inReady, 1'b1);
    check("bp outValid after take", outValid, 1'b0);
    @(posedge clk);
    #1;
    check("bp nothing queued", busy, 1'b0);

    // Abort in mid-RUN; outReady during RUN must not matter either.
    multiplicand = 16'h1234;
    multiplier   = 16'h5678;
    signedFlag   = 1'b1;
    inValid      = 1'b1;
    @(posedge clk);
    #1;
    inValid  = 1'b0;
    outReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    outReady = 1'b0;
    check("abort busy in run", busy, 1'b1);
    check("abort outValid in run", outValid, 1'b0);
    rstN = 1'b0;
    #1;
    check("abort inReady", inReady, 1'b1);
    check("abort outValid", outValid, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort product", product, 32'h0);
    #2;
    rstN = 1'b1;
    @(posedge clk);
    #1;
    run_op("after abort", 16'h0003, 16'h0005, 1'b0, 32'h0000000F);

    check("scoreboard drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
